// File: rtl/fp_mantissa_align.sv
// Exponent compare + smaller-significand right shift with guard/round/sticky; result held until out_ready.
// Latency 1 + shift cycles. `ALIGN_FAST_SHIFT_EN moves up to 4 bits per SHIFT cycle instead of 1.
module fp_mantissa_align #(
   parameter int MAX_SHIFT = 56
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [10:0] expA,
   input  logic [10:0] expB,
   input  logic [52:0] manA,
   input  logic [52:0] manB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [10:0] exp_out,
   output logic [52:0] man_big,
   output logic [55:0] man_small,
   output logic        swapped
);
   localparam int               CNT_W        = $clog2(MAX_SHIFT + 1);
   localparam logic [11:0]      MAX_SHIFT_12 = 12'(MAX_SHIFT);
   localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_SHIFT);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [10:0]      exp_out_q, exp_out_d;
   logic [52:0]      man_big_q, man_big_d;
   logic [55:0]      man_small_q, man_small_d;
   logic             swapped_q, swapped_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             in_swap;
   logic [11:0]      exp_diff;
   logic [CNT_W-1:0] in_count;
   logic [CNT_W-1:0] step;

   // Tie goes to A, so swapped only on a strict B > A.
   always_comb begin
      in_swap  = expB > expA;
      exp_diff = in_swap ? ({1'b0, expB} - {1'b0, expA}) : ({1'b0, expA} - {1'b0, expB});
      in_count = (exp_diff > MAX_SHIFT_12) ? MAX_CNT : exp_diff[CNT_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      exp_out_d   = exp_out_q;
      man_big_d   = man_big_q;
      man_small_d = man_small_q;
      swapped_d   = swapped_q;
      count_d     = count_q;
      step        = '0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               swapped_d   = in_swap;
               exp_out_d   = in_swap ? expB : expA;
               man_big_d   = in_swap ? manB : manA;
               man_small_d = {(in_swap ? manA : manB), 3'b000};
               count_d     = in_count;
               state_d     = (in_count == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Bit 0 is sticky: it absorbs every bit shifted past it.
`ifdef ALIGN_FAST_SHIFT_EN
            step = (count_q > CNT_W'(4)) ? CNT_W'(4) : count_q;
            case (step)
               CNT_W'(1): man_small_d = {1'b0, man_small_q[55:2], |man_small_q[1:0]};
               CNT_W'(2): man_small_d = {2'b0, man_small_q[55:3], |man_small_q[2:0]};
               CNT_W'(3): man_small_d = {3'b0, man_small_q[55:4], |man_small_q[3:0]};
               default:   man_small_d = {4'b0, man_small_q[55:5], |man_small_q[4:0]};
            endcase
`else
            step        = CNT_W'(1);
            man_small_d = {1'b0, man_small_q[55:2], |man_small_q[1:0]};
`endif
            count_d = count_q - step;
            if (count_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         exp_out_q   <= '0;
         man_big_q   <= '0;
         man_small_q <= '0;
         swapped_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         exp_out_q   <= exp_out_d;
         man_big_q   <= man_big_d;
         man_small_q <= man_small_d;
         swapped_q   <= swapped_d;
         count_q     <= count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign exp_out   = exp_out_q;
   assign man_big   = man_big_q;
   assign man_small = man_small_q;
   assign swapped   = swapped_q;
endmodule

// File: tb/tb_fp_mantissa_align.sv
// Scoreboard bench for fp_mantissa_align: directed test-plan cases plus randomized operands against a reference model.
module tb_fp_mantissa_align;
   localparam int MAXS = 56;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [10:0] expA, expB;
   logic [52:0] manA, manB;
   logic        in_ready, out_valid, swapped;
   logic [10:0] exp_out;
   logic [52:0] man_big;
   logic [55:0] man_small;

   fp_mantissa_align #(.MAX_SHIFT(MAXS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .expA(expA), .expB(expB), .manA(manA), .manB(manB),
      .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
      .man_big(man_big), .man_small(man_small), .swapped(swapped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] e;
      logic [52:0] mb;
      logic [55:0] ms;
      logic        sw;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0;
   int   last_hs = 0;
   bit   ov_prev = 0, hs_prev = 0, rand_rdy = 0;

   always @(posedge clk) cyc++;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic int shifts(input int c);
`ifdef ALIGN_FAST_SHIFT_EN
      return (c + 3) / 4;
`else
      return c;
`endif
   endfunction

   function automatic exp_t mk(input logic [10:0] e, input logic [52:0] mb, input logic [55:0] ms,
                               input logic sw, input int cnt);
      exp_t r;
      r.e = e; r.mb = mb; r.ms = ms; r.sw = sw; r.lat = 1 + shifts(cnt); r.acc = 0;
      return r;
   endfunction

   // Reference: align by a plain wide shift, sticky = OR of everything at or below the new LSB.
   function automatic exp_t model(input logic [10:0] ea, input logic [10:0] eb,
                                  input logic [52:0] ma, input logic [52:0] mbv);
      int d, c;
      logic sw;
      longint unsigned orig, res, mask;
      d = int'(ea) - int'(eb);
      if (d < 0) d = -d;
      c = (d > MAXS) ? MAXS : d;
      sw = (eb > ea);
      orig = {8'b0, (sw ? ma : mbv), 3'b000};
      mask = (64'd1 << (c + 1)) - 64'd1;
      res  = orig >> c;
      if ((orig & mask) != 0) res = res | 64'd1;
      return mk(sw ? eb : ea, sw ? mbv : ma, res[55:0], sw, c);
   endfunction

   function automatic logic [52:0] rand_man(input bit hidden);
      logic [63:0] r;
      r = {$urandom, $urandom};
      if (hidden) r[52] = 1'b1;
      return r[52:0];
   endfunction

   // Monitor: compares every presented result against the queue head; pops on handshake.
   always @(negedge clk) begin
      if (reset) begin
         ov_prev = 0;
         hs_prev = 0;
      end else begin
         if (hs_prev) begin
            check("in_ready_after_handshake", 64'(in_ready), 64'd1);
            hs_prev = 0;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("out_valid_without_expect", 64'(out_valid), 64'd0);
            end else begin
               mon_x = sb[0];
               if (!ov_prev) check("latency", 64'(cyc - mon_x.acc + 1), 64'(mon_x.lat));
               check("exp_out", 64'(exp_out), 64'(mon_x.e));
               check("man_big", 64'(man_big), 64'(mon_x.mb));
               check("man_small", 64'(man_small), 64'(mon_x.ms));
               check("swapped", 64'(swapped), 64'(mon_x.sw));
               check("in_ready_while_busy", 64'(in_ready), 64'd0);
               if (out_ready) begin
                  void'(sb.pop_front());
                  hs_prev = 1;
                  last_hs = cyc + 1;
               end
            end
         end
         ov_prev = out_valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [10:0] ea, input logic [10:0] eb, input logic [52:0] ma,
                        input logic [52:0] mbv, input exp_t e, input bit hold, input bit chk_sp);
      bit ok;
      expA = ea; expB = eb; manA = ma; manB = mbv; in_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc + 1;
      if (chk_sp) check("accept_after_handshake", 64'(e.acc - last_hs), 64'd1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] ea, eb, tmp;
      logic [52:0] ma, mbv;
      int          d, mode;
      bit          ok;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      expA = '0; expB = '0; manA = '0; manB = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_exp_out", 64'(exp_out), 64'd0);
      check("rst_man_big", 64'(man_big), 64'd0);
      check("rst_man_small", 64'(man_small), 64'd0);
      check("rst_swapped", 64'(swapped), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Equal exponents
      issue(11'd1023, 11'd1023, 53'h10000000000000, 53'h18000000000000,
            mk(11'd1023, 53'h10000000000000, 56'hC0000000000000, 1'b0, 0), 0, 0);
      wait_idle();
      // Swap and shift by 3
      issue(11'd1020, 11'd1023, 53'h10000000000000, 53'h10000000000000,
            mk(11'd1023, 53'h10000000000000, 56'h10000000000000, 1'b1, 3), 0, 0);
      wait_idle();
      // Saturation with sticky
      issue(11'd1023, 11'd963, 53'h10000000000000, 53'h1,
            mk(11'd1023, 53'h10000000000000, 56'h1, 1'b0, 56), 0, 0);
      wait_idle();
      // Saturation of a zero significand
      issue(11'd0, 11'd2047, 53'h0, 53'h1FFFFFFFFFFFFF,
            mk(11'd2047, 53'h1FFFFFFFFFFFFF, 56'h0, 1'b1, 56), 0, 0);
      wait_idle();

      // Backpressure: result held while junk is offered on the input
      out_ready = 1'b0;
      issue(11'd5, 11'd7, 53'h1FFFFFFFFFFFFF, 53'h15555555555555,
            model(11'd5, 11'd7, 53'h1FFFFFFFFFFFFF, 53'h15555555555555), 0, 0);
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("backpressure_valid_timeout", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      expA = 11'd100; expB = 11'd3; manA = 53'h0ABCDEF; manB = 53'h123; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset in the middle of a saturated shift
      issue(11'd1023, 11'd963, 53'h10000000000000, 53'h1,
            mk(11'd1023, 53'h10000000000000, 56'h1, 1'b0, 56), 0, 0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_man_small", 64'(man_small), 64'd0);
      check("midrst_exp_out", 64'(exp_out), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      issue(11'd1023, 11'd1023, 53'h10000000000000, 53'h18000000000000,
            mk(11'd1023, 53'h10000000000000, 56'hC0000000000000, 1'b0, 0), 0, 0);
      wait_idle();

      // Back-to-back with in_valid and out_ready held high
      issue(11'd1023, 11'd1020, 53'h1F000000000000, 53'h1AAAAAAAAAAAAB,
            model(11'd1023, 11'd1020, 53'h1F000000000000, 53'h1AAAAAAAAAAAAB), 1, 0);
      issue(11'd500, 11'd500, 53'h12345678ABCDE, 53'h1FFFFFFFFFFFFF,
            model(11'd500, 11'd500, 53'h12345678ABCDE, 53'h1FFFFFFFFFFFFF), 0, 1);
      wait_idle();

      // Randomized operands with random output backpressure
      rand_rdy = 1;
      for (int i = 0; i < 60; i++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0: d = 0;
            1: d = $urandom_range(1, 8);
            2: d = $urandom_range(9, 60);
            default: d = $urandom_range(61, 2047);
         endcase
         ea = 11'($urandom_range(0, 2047));
         if (int'(ea) + d <= 2047) eb = 11'(int'(ea) + d);
         else if (int'(ea) - d >= 0) eb = 11'(int'(ea) - d);
         else eb = 11'd2047;
         if ($urandom_range(0, 1) == 1) begin
            tmp = ea; ea = eb; eb = tmp;
         end
         ma  = rand_man($urandom_range(0, 3) != 0);
         mbv = rand_man($urandom_range(0, 3) != 0);
         issue(ea, eb, ma, mbv, model(ea, eb, ma, mbv), 0, 0);
      end
      rand_rdy = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
